fetch_redirect: RTL

Fetch-side consumer of the branch unit's resolution outputs. It owns the architectural fetch PC and issues one 16-byte VLIW bundle request per cycle to instruction memory. It applies taken-branch/jump redirects with the correct decode/execute squash pulses, and sequences the processor halt on ecall/ebreak. It sits between the branch execute slot and the imem port and decode stage.

---
 rtl/fetch_redirect_pkg.sv | 13 +
 rtl/fetch_redirect.sv | 111 +++++++++++
 2 files changed

// File: rtl/fetch_redirect_pkg.sv
// Shared fetch-side types and bundle geometry, also used by branch execute and decode.
package fetch_redirect_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    localparam logic [31:0] BUNDLE_BYTES = 32'd16;
    localparam logic [31:0] BUNDLE_MASK  = 32'hFFFF_FFF0;

endpackage

// File: rtl/fetch_redirect.sv
// Fetch PC owner: sequential bundle requests, branch redirects with squash pulses,
// and the ecall/ebreak halt sequence.
module fetch_redirect
    import fetch_redirect_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned HALT_DRAIN = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_new_pc,
    input  logic        br_dont_squash_dec,
    input  logic        br_dont_squash_exec,
    input  logic        br_halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic        squash_dec,
    output logic        squash_exec,
    output logic        halted
);

    localparam logic [3:0] DRAIN_LAST = 4'(HALT_DRAIN - 1);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic         redirect_pend_q, redirect_pend_d;
    logic [3:0]   drain_cnt_q, drain_cnt_d;
    logic         fetch_valid_q, fetch_valid_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= RUN;
            pc_q            <= RESET_PC;
            redirect_pend_q <= 1'b0;
            drain_cnt_q     <= 4'd0;
            fetch_valid_q   <= 1'b0;
            fetch_pc_q      <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            redirect_pend_q <= redirect_pend_d;
            drain_cnt_q     <= drain_cnt_d;
            fetch_valid_q   <= fetch_valid_d;
            fetch_pc_q      <= fetch_pc_d;
        end
    end

    assign imem_addr   = pc_q & BUNDLE_MASK;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign halted      = (state_q == HALTED);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        redirect_pend_d = redirect_pend_q;
        drain_cnt_d     = drain_cnt_q;
        fetch_valid_d   = 1'b0;
        fetch_pc_d      = fetch_pc_q;
        imem_req        = 1'b0;
        squash_dec      = 1'b0;
        squash_exec     = 1'b0;

        unique case (state_q)
            RUN: begin
                // Combinational outputs are masked while reset is held.
                imem_req = ~rst;
                if (br_halt) begin
                    squash_dec      = ~rst;
                    squash_exec     = ~rst;
                    state_d         = DRAIN;
                    drain_cnt_d     = 4'd0;
                    redirect_pend_d = 1'b0;
                end else if (br_taken) begin
                    squash_dec      = ~rst & ~br_dont_squash_dec;
                    squash_exec     = ~rst & ~br_dont_squash_exec;
                    // This cycle's grant was for the old path and is discarded.
                    pc_d            = br_new_pc & BUNDLE_MASK;
                    redirect_pend_d = 1'b1;
                end else if (imem_gnt) begin
                    redirect_pend_d = 1'b0;
                    if (!stall) begin
                        fetch_valid_d = 1'b1;
                        fetch_pc_d    = imem_addr;
                        pc_d          = imem_addr + BUNDLE_BYTES;
                    end
                end
            end
            DRAIN: begin
                if (drain_cnt_q == DRAIN_LAST) begin
                    state_d = HALTED;
                end else begin
                    drain_cnt_d = drain_cnt_q + 4'd1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

endmodule
